// File: rtl/mitchell_product_accumulator.sv
// Vector accumulator for sign-magnitude Mitchell multiplier products.
// Sums one dot-product row in a wide two's-complement register and emits a
// saturated sign-magnitude result in the input format once the row closes.
module mitchell_product_accumulator #(
  parameter int unsigned BITSIZE = 16,
  parameter int unsigned FRAC    = 11,
  parameter int unsigned GUARD   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [BITSIZE-1:0] in_data,
  input  logic               in_valid,
  input  logic               in_last,
  output logic               in_ready,
  output logic [BITSIZE-1:0] out_data,
  output logic               out_sat,
  output logic [GUARD:0]     out_count,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned W = BITSIZE + GUARD;
  // Count value just before the term that fills a full 2^GUARD vector.
  localparam logic [GUARD:0] LastCnt = {1'b0, {GUARD{1'b1}}};
  localparam logic [GUARD:0] CntOne  = 1;

  // The binary point only passes through; the format just has to be sane.
  if (FRAC > BITSIZE - 1) begin : g_frac_check
    $error("FRAC must not exceed BITSIZE-1");
  end

  typedef enum logic {StAcc, StHold} state_e;

  state_e               state_q, state_d;
  logic [W-1:0]         acc_q;
  logic [GUARD:0]       cnt_q;

  logic [W-1:0]         mag;
  logic [W-1:0]         term;
  logic [W-1:0]         sum;
  logic [W-1:0]         abs_sum;
  logic                 sum_sat;
  logic [BITSIZE-1:0]   sum_fmt;
  logic                 accept;
  logic                 close;

  assign in_ready  = (state_q == StAcc) & ~rst;
  assign out_valid = (state_q == StHold);
  assign accept    = in_valid & in_ready;
  assign close     = accept & (in_last | (cnt_q == LastCnt));

  // Term conversion, running sum and saturating sign-magnitude formatting.
  always_comb begin
    mag     = {{(GUARD + 1){1'b0}}, in_data[BITSIZE-2:0]};
    term    = in_data[BITSIZE-1] ? (~mag + 1'b1) : mag;
    sum     = acc_q + term;
    abs_sum = sum[W-1] ? (~sum + 1'b1) : sum;
    // Any set bit at or above the sign position means |s| exceeds the format.
    sum_sat = |abs_sum[W-1:BITSIZE-1];
    // A zero sum is non-negative, so it never carries a sign bit.
    sum_fmt = {sum[W-1], sum_sat ? {(BITSIZE - 1){1'b1}} : abs_sum[BITSIZE-2:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StAcc;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: close a vector into HOLD, leave HOLD on the output handshake.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StAcc:   if (close) state_d = StHold;
      StHold:  if (out_ready) state_d = StAcc;
      default: state_d = StAcc;
    endcase
  end

  // Accumulator, term counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      out_data  <= '0;
      out_sat   <= 1'b0;
      out_count <= '0;
    end else if (accept) begin
      if (close) begin
        out_data  <= sum_fmt;
        out_sat   <= sum_sat;
        out_count <= cnt_q + CntOne;
        acc_q     <= '0;
        cnt_q     <= '0;
      end else begin
        acc_q <= sum;
        cnt_q <= cnt_q + CntOne;
      end
    end
  end

endmodule

// File: tb/tb_mitchell_product_accumulator.sv
// Self-checking bench for mitchell_product_accumulator: directed scenarios
// followed by random vectors compared against an integer-arithmetic model.
module tb_mitchell_product_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic [8:0]  out_count;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;

  mitchell_product_accumulator #(
    .BITSIZE(16),
    .FRAC   (11),
    .GUARD  (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sat  (out_sat),
    .out_count(out_count),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Signed value of a sign-magnitude product.
  function automatic int term_val(input logic [15:0] d);
    int m;
    m = int'({17'b0, d[14:0]});
    return d[15] ? -m : m;
  endfunction

  // Returns {sat, data} for an exact integer sum.
  function automatic logic [16:0] fmt(input int s);
    int a;
    a = (s < 0) ? -s : s;
    if (a > 32767) return {1'b1, (s < 0), 15'h7FFF};
    return {1'b0, (s < 0), a[14:0]};
  endfunction

  // Present one term and hold it until accepted; returns #1 after the accepting edge.
  task automatic send(input logic [15:0] d, input logic l);
    int waited = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [15:0] d, input logic s,
                               input logic [8:0] c);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_data"}, {16'b0, out_data}, {16'b0, d});
    check({tag, "_sat"}, {31'b0, out_sat}, {31'b0, s});
    check({tag, "_count"}, {23'b0, out_count}, {23'b0, c});
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, {31'b0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] d;
    logic [16:0] m;
    int          s;
    int          len;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready_low", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {16'b0, out_data}, 32'd0);
    check("rst_out_sat", {31'b0, out_sat}, 32'd0);
    check("rst_out_count", {23'b0, out_count}, 32'd0);

    // Three-term vector with the consumer always ready.
    out_ready = 1'b1;
    send(16'h0800, 1'b0);
    check("v3_no_early_valid", {31'b0, out_valid}, 32'd0);
    send(16'h0800, 1'b0);
    send(16'h8400, 1'b1);
    expect_result("v3", 16'h0C00, 1'b0, 9'd3);
    check("v3_in_ready_hold", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    check("v3_one_cycle", {31'b0, out_valid}, 32'd0);
    check("v3_ready_again", {31'b0, in_ready}, 32'd1);
    out_ready = 1'b0;

    // Saturation in both directions.
    send(16'h7FFF, 1'b0);
    send(16'h0001, 1'b1);
    expect_result("sat_pos", 16'h7FFF, 1'b1, 9'd2);
    consume("sat_pos");
    send(16'hFFFF, 1'b0);
    send(16'h8001, 1'b1);
    expect_result("sat_neg", 16'hFFFF, 1'b1, 9'd2);
    consume("sat_neg");

    // Zero sums never report negative zero.
    send(16'h0800, 1'b0);
    send(16'h8800, 1'b1);
    expect_result("zero_cancel", 16'h0000, 1'b0, 9'd2);
    consume("zero_cancel");
    send(16'h8000, 1'b1);
    expect_result("neg_zero", 16'h0000, 1'b0, 9'd1);
    consume("neg_zero");

    // Backpressure: result held, nothing accepted while offered data waits.
    send(16'h0300, 1'b1);
    in_data  = 16'h0100;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_valid_%0d", i), {31'b0, out_valid}, 32'd1);
      check($sformatf("bp_data_%0d", i), {16'b0, out_data}, 32'h0300);
      check($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    check("bp_valid_drop", {31'b0, out_valid}, 32'd0);
    check("bp_ready_back", {31'b0, in_ready}, 32'd1);
    send(16'h0200, 1'b1);
    expect_result("bp_next", 16'h0200, 1'b0, 9'd1);
    consume("bp_next");

    // Forced close at 2^GUARD terms; the following term opens a new vector.
    for (int i = 0; i < 256; i++) begin
      send(16'h0001, 1'b0);
      if (i == 254) check("force_not_yet", {31'b0, out_valid}, 32'd0);
    end
    expect_result("force", 16'h0100, 1'b0, 9'd256);
    consume("force");
    send(16'h0001, 1'b1);
    expect_result("force_next", 16'h0001, 1'b0, 9'd1);
    consume("force_next");

    // Reset mid-vector drops the partial sum and clears the outputs.
    send(16'h0800, 1'b0);
    send(16'h0800, 1'b0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_data", {16'b0, out_data}, 32'd0);
    check("mid_rst_sat", {31'b0, out_sat}, 32'd0);
    check("mid_rst_count", {23'b0, out_count}, 32'd0);
    check("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    send(16'h0400, 1'b1);
    expect_result("after_rst", 16'h0400, 1'b0, 9'd1);
    consume("after_rst");

    // Random vectors with idle gaps and random consumer delay.
    for (int v = 0; v < 40; v++) begin
      len = $urandom_range(1, 8);
      s   = 0;
      for (int i = 0; i < len; i++) begin
        d = 16'($urandom);
        if ($urandom_range(0, 2) != 0) d[14:10] = '0;
        s += term_val(d);
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        send(d, i == len - 1);
      end
      m = fmt(s);
      expect_result($sformatf("rnd%0d", v), m[15:0], m[16], 9'(len));
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk);
        #1;
        check($sformatf("rnd%0d_hold", v), {16'b0, out_data}, {16'b0, m[15:0]});
      end
      consume($sformatf("rnd%0d", v));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mitchell_product_accumulator.md
# mitchell_product_accumulator

Downstream consumer of the Mitchell log-domain fixed-point multiplier. It takes a stream of sign-magnitude Q(BITSIZE-1-FRAC).FRAC products and sums each vector of products (a dot-product row) in a wide two's-complement accumulator. When the vector closes it returns one saturated sign-magnitude result in the same format. Valid/ready handshakes on both sides let the block sit between the multiplier array and the activation/writeback stage.

## Interface
- BITSIZE, 16, width of input product and output sum; sign-magnitude, bit BITSIZE-1 is the sign.
- FRAC, 11, fractional bits. Passes through only; the sum is format-preserving.
- GUARD, 8, accumulator guard bits. The maximum vector length is 2^GUARD terms.

- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_data  in  BITSIZE  product from the multiplier, sign-magnitude.
- in_valid  in  1  in_data/in_last are valid.
- in_last  in  1  marks the final term of the current vector.
- in_ready  out  1  the block accepts a term this cycle.
- out_data  out  BITSIZE  saturated vector sum, sign-magnitude.
- out_sat  out  1  out_data was clamped.
- out_count  out  GUARD+1  number of terms in the vector, 1..2^GUARD.
- out_valid  out  1  the out_* signals are valid.
- out_ready  in  1  the consumer takes the result.

## Operation
- Two states.
  - ACC: in_ready=1.
  - HOLD: in_ready=0 and out_valid=1.
- Reset puts the block in ACC. in_ready is forced to 0 while rst=1.
- Term conversion: magnitude = in_data[BITSIZE-2:0], zero-extended to the accumulator width W = BITSIZE+GUARD. It is negated when the sign bit is 1. Input 0x8000 (negative zero) adds 0.
- Accept: when in_valid & in_ready, then acc <= acc + term and cnt <= cnt + 1.
- A vector closes on an accepted term with in_last=1. It also closes on an accepted term that makes cnt = 2^GUARD (forced close; in_last is then ignored).
- On close:
  - the final value s = acc + term is registered into the outputs;
  - out_count = cnt + 1;
  - acc and cnt clear to 0;
  - state goes to HOLD.
- Output formatting:
  - If |s| > 2^(BITSIZE-1)-1, the output magnitude is all ones, the sign is s's sign, and out_sat=1.
  - Otherwise the output is the exact magnitude and out_sat=0.
  - A zero sum always outputs sign 0 (0x0000, never 0x8000).
- The accumulator cannot overflow: 2^GUARD terms of magnitude < 2^(BITSIZE-1) fit in W-bit signed.
- HOLD: the out_* signals stay stable until out_valid & out_ready. On that cycle the state returns to ACC and out_valid drops the next cycle. No input is accepted while in HOLD.
- rst asserted in any state:
  - aborts the partial vector with no output;
  - clears acc, cnt, out_data, out_sat and out_count to 0;
  - sets out_valid=0 and state=ACC.

## Timing
- Reset values: out_data=0, out_sat=0, out_count=0, out_valid=0. in_ready=1 on the first cycle after rst deasserts.
- Throughput: one term per cycle within a vector.
- Latency: out_valid rises the cycle after the closing term is accepted.
- At least one dead cycle separates vectors: in_ready=0 during HOLD. in_ready=1 again the cycle after the handshake.
- in_ready depends only on state and rst, never combinationally on in_valid or out_ready.
- A single-term vector (in_last on the first term) is legal. It produces out_count=1.
- in_valid without in_ready has no effect. The upstream stage must hold its data until accepted.

## Test plan
- Sum of a three-term vector:
  - Stimulus: 0x0800, 0x0800, 0x8400 (1.0, 1.0, -0.5), in_last on the third, out_ready=1.
  - Required: out_data=0x0C00, out_sat=0, out_count=3, out_valid high exactly one cycle, starting one cycle after the third accept.
- Saturation:
  - 0x7FFF, 0x0001 with last -> out_data=0x7FFF, out_sat=1.
  - 0xFFFF, 0x8001 with last -> out_data=0xFFFF, out_sat=1.
- Zero handling:
  - 0x0800, 0x8800 with last -> 0x0000, out_sat=0.
  - Lone 0x8000 with last -> 0x0000, out_count=1.
- Backpressure:
  - Close a vector, then hold out_ready=0 for 5 cycles -> out_* stable, in_ready=0 throughout.
  - Then raise out_ready -> handshake; in_ready=1 the following cycle; the next vector accumulates from 0.
- Forced close: 256 consecutive terms of 0x0001 with in_last=0 -> out_data=0x0100, out_count=256, out_sat=0. Term 257 starts a new vector.
- Reset mid-vector:
  - Accept 0x0800 and 0x0800, pulse rst for one cycle -> no out_valid, and all outputs read 0.
  - Then send 0x0400 with last -> out_data=0x0400, out_count=1.
